// File: rtl/hpm_counter_bank.sv
// Bank of NUM_CNT hardware performance counters with selectable events,
// per-counter inhibit, sticky overflow flags and a level overflow interrupt.
module hpm_counter_bank #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 16,
  parameter int SEL_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_EVT-1:0] evt_vec,
  input  logic               csr_we,
  input  logic               csr_re,
  input  logic [7:0]         csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               csr_rvalid,
  output logic               irq
);

  localparam int EXT_W = 2 ** SEL_W;
  localparam int HI_W  = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] cnt   [NUM_CNT];
  logic [SEL_W-1:0]     evsel [NUM_CNT];
  logic [NUM_CNT-1:0]   inhibit, ovf, ovf_en;
  logic [NUM_CNT-1:0]   inc, wrap, wr_lo, wr_hi, wr_sel;
  logic [EXT_W-1:0]     evt_ext;
  logic                 wr_inh, wr_ovf, wr_en;
  logic [31:0]          rd_mux;

  // Zero-padding the event vector to the full select range makes any
  // select >= NUM_EVT read a 0, so no separate range compare is needed.
  assign evt_ext = EXT_W'(evt_vec);

  assign wr_inh = csr_we && (csr_addr == 8'h60);
  assign wr_ovf = csr_we && (csr_addr == 8'h61);
  assign wr_en  = csr_we && (csr_addr == 8'h62);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      assign wr_lo[gi]  = csr_we && (csr_addr == 8'(gi));
      assign wr_hi[gi]  = csr_we && (csr_addr == 8'(32 + gi));
      assign wr_sel[gi] = csr_we && (csr_addr == 8'(64 + gi));
      assign inc[gi]    = evt_ext[evsel[gi]] && (evsel[gi] != '0) && !inhibit[gi];
      // A half-write suppresses the increment, so it can never wrap either.
      assign wrap[gi]   = inc[gi] && !wr_lo[gi] && !wr_hi[gi] && (&cnt[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]   <= '0;
        evsel[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_lo[i]) begin
          cnt[i][31:0] <= csr_wdata;
        end else if (wr_hi[i]) begin
          cnt[i][CNT_WIDTH-1:32] <= csr_wdata[HI_W-1:0];
        end else if (inc[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
        if (wr_sel[i]) begin
          evsel[i] <= csr_wdata[SEL_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inhibit <= '0;
      ovf_en  <= '0;
      ovf     <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_inh) inhibit <= csr_wdata[NUM_CNT-1:0];
      if (wr_en)  ovf_en  <= csr_wdata[NUM_CNT-1:0];
      ovf <= (ovf & ~(wr_ovf ? csr_wdata[NUM_CNT-1:0] : '0)) | wrap;
      irq <= |(ovf & ovf_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_addr == 8'(i))      rd_mux = cnt[i][31:0];
      if (csr_addr == 8'(32 + i)) rd_mux = 32'(cnt[i][CNT_WIDTH-1:32]);
      if (csr_addr == 8'(64 + i)) rd_mux = 32'(evsel[i]);
    end
    case (csr_addr)
      8'h60:   rd_mux = 32'(inhibit);
      8'h61:   rd_mux = 32'(ovf);
      8'h62:   rd_mux = 32'(ovf_en);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_re;
      if (csr_re) csr_rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Randomised + directed bench for hpm_counter_bank against a behavioural
// model of the counter bank, compared on every cycle.
module tb_hpm_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] evt_vec = '0;
  logic        csr_we = 1'b0;
  logic        csr_re = 1'b0;
  logic [7:0]  csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  bit [63:0] m_cnt [4];
  bit [7:0]  m_sel [4];
  bit [3:0]  m_inh, m_ovf, m_en;
  bit        m_irq, m_rvalid;
  bit [31:0] m_rdata;

  hpm_counter_bank dut (
    .clk(clk), .rst_n(rst_n), .evt_vec(evt_vec),
    .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input bit [63:0] act, input bit [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = '0;
      m_sel[i] = '0;
    end
    m_inh = '0; m_ovf = '0; m_en = '0;
    m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  function automatic bit [31:0] model_read(input bit [7:0] a);
    int idx;
    idx = int'(a[4:0]);
    case (a[7:5])
      3'd0: return (idx < 4) ? m_cnt[idx][31:0] : 32'd0;
      3'd1: return (idx < 4) ? m_cnt[idx][63:32] : 32'd0;
      3'd2: return (idx < 4) ? 32'(m_sel[idx]) : 32'd0;
      3'd3: begin
        if (idx == 0) return 32'(m_inh);
        if (idx == 1) return 32'(m_ovf);
        if (idx == 2) return 32'(m_en);
        return 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    bit [63:0] nc [4];
    bit [3:0]  wrapv;
    bit        hit, nirq;
    wrapv = '0;
    nirq = |(m_ovf & m_en);
    if (csr_re) m_rdata = model_read(csr_addr);
    m_rvalid = csr_re;
    for (int i = 0; i < 4; i++) begin
      hit = 1'b0;
      if (m_sel[i] != 0 && m_sel[i] < 16 && !m_inh[i]) hit = evt_vec[m_sel[i][3:0]];
      nc[i] = m_cnt[i];
      if (csr_we && csr_addr == 8'(i)) nc[i][31:0] = csr_wdata;
      else if (csr_we && csr_addr == 8'(32 + i)) nc[i][63:32] = csr_wdata;
      else if (hit) begin
        if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) wrapv[i] = 1'b1;
        nc[i] = m_cnt[i] + 64'd1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = nc[i];
      if (csr_we && csr_addr == 8'(64 + i)) m_sel[i] = csr_wdata[7:0];
    end
    if (csr_we && csr_addr == 8'h60) m_inh = csr_wdata[3:0];
    if (csr_we && csr_addr == 8'h62) m_en = csr_wdata[3:0];
    if (csr_we && csr_addr == 8'h61) m_ovf = m_ovf & ~csr_wdata[3:0];
    m_ovf = m_ovf | wrapv;
    m_irq = nirq;
  endtask

  task automatic compare();
    chk("rvalid", 64'(csr_rvalid), 64'(m_rvalid));
    chk("irq", 64'(irq), 64'(m_irq));
    if (m_rvalid) chk("rdata", 64'(csr_rdata), 64'(m_rdata));
    chk("ovf", 64'(dut.ovf), 64'(m_ovf));
    for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), dut.cnt[i], m_cnt[i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic wr(input bit [7:0] a, input bit [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input bit [7:0] a);
    csr_re = 1'b1; csr_addr = a;
    step();
    csr_re = 1'b0;
  endtask

  initial begin
    int k;
    model_reset();
    #12;
    chk("reset_rdata", 64'(csr_rdata), 64'd0);
    chk("reset_irq", 64'(irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic counting
    wr(8'h40, 32'd3);
    evt_vec = 16'h0008;
    repeat (10) step();
    evt_vec = '0;
    rd(8'h00);
    chk("basic_count", 64'(csr_rdata), 64'd10);
    chk("basic_rvalid", 64'(csr_rvalid), 64'd1);
    step();
    chk("basic_pulse", 64'(csr_rvalid), 64'd0);
    chk("basic_cnt1", dut.cnt[1], 64'd0);

    // Event 0 and out-of-range selects
    wr(8'h41, 32'd0);
    wr(8'h42, 32'd200);
    evt_vec = 16'hFFFF;
    repeat (5) step();
    chk("evt0_cnt1", dut.cnt[1], 64'd0);
    chk("range_cnt2", dut.cnt[2], 64'd0);
    rd(8'h1F);
    chk("unmapped", 64'(csr_rdata), 64'd0);

    // Inhibit and write priority
    wr(8'h40, 32'd2);
    evt_vec = 16'h0004;
    repeat (3) step();
    wr(8'h60, 32'h1);
    repeat (3) step();
    wr(8'h60, 32'h0);
    wr(8'h00, 32'hDEADBEEF);
    chk("wr_wins", 64'(dut.cnt[0][31:0]), 64'hDEADBEEF);
    evt_vec = '0;

    // Carry and overflow
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h20, 32'h0);
    evt_vec = 16'h0004; step(); evt_vec = '0;
    chk("carry", dut.cnt[0], 64'h1_0000_0000);
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h20, 32'hFFFF_FFFF);
    wr(8'h62, 32'h1);
    evt_vec = 16'h0004; step(); evt_vec = '0;
    chk("wrap_cnt", dut.cnt[0], 64'd0);
    chk("wrap_ovf", 64'(dut.ovf), 64'h1);
    step();
    chk("irq_set", 64'(irq), 64'd1);
    wr(8'h61, 32'h1);
    step();
    chk("irq_clr", 64'(irq), 64'd0);

    // Set beats clear; read-during-write returns the old value
    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h20, 32'hFFFF_FFFF);
    evt_vec = 16'h0004;
    wr(8'h61, 32'h1);
    evt_vec = '0;
    chk("set_wins", 64'(dut.ovf), 64'h1);
    csr_we = 1'b1; csr_re = 1'b1; csr_addr = 8'h00; csr_wdata = 32'h5;
    step();
    csr_we = 1'b0; csr_re = 1'b0;
    chk("rw_old", 64'(csr_rdata), 64'd0);
    rd(8'h00);
    chk("rw_new", 64'(csr_rdata), 64'd5);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      evt_vec = 16'($urandom);
      csr_we = ($urandom_range(0, 3) == 0);
      csr_re = ($urandom_range(0, 1) == 0);
      k = $urandom_range(0, 15);
      csr_wdata = $urandom;
      if (k < 4) begin
        csr_addr = 8'(k);
        if ($urandom_range(0, 1) == 1) csr_wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      end else if (k < 8) begin
        csr_addr = 8'(32 + k - 4);
        if ($urandom_range(0, 1) == 1) csr_wdata = 32'hFFFF_FFFF;
      end else if (k < 12) begin
        csr_addr = 8'(64 + k - 8);
        csr_wdata = 32'($urandom_range(0, 17));
      end else if (k < 15) begin
        csr_addr = 8'(96 + k - 12);
        if (k == 12 && $urandom_range(0, 2) != 0) csr_wdata = 32'h0;
      end else begin
        csr_addr = 8'($urandom_range(0, 127));
      end
      step();
    end
    csr_we = 1'b0; csr_re = 1'b0;

    // Asynchronous reset between edges with a read in flight
    wr(8'h40, 32'd2);
    evt_vec = 16'h0004;
    csr_re = 1'b1; csr_addr = 8'h00;
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_rdata", 64'(csr_rdata), 64'd0);
    chk("arst_rvalid", 64'(csr_rvalid), 64'd0);
    chk("arst_irq", 64'(irq), 64'd0);
    chk("arst_cnt0", dut.cnt[0], 64'd0);
    csr_re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_no_rvalid", 64'(csr_rvalid), 64'd0);
    step();
    chk("arst_restart", dut.cnt[0], 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
